// File: rtl/program_loader.sv
// Loads framed instruction words from a byte stream into the instruction ROM.
// Frame: SYNC_BYTE, N, 3*N payload bytes, then the checksum (N + payload) mod 256.
module program_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_w_enable,
  output logic [ADDR_W-1:0] rom_w_addr,
  output logic [23:0]       rom_w_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_error,
  output logic [2:0]        dbg_state
);
  localparam int IDLE_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_B0, S_B1, S_B2, S_CHECK, S_RESULT
  } state_t;

  // Byte handshake: a byte moves only in a cycle where rx_valid && rx_ready.
  // rx_ready is registered, so it is known before the cycle starts.
  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          sum_q, sum_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [7:0]          op_q, op_d;
  logic [7:0]          arg_a_q, arg_a_d;
  logic                rx_ready_q, rx_ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [23:0]         wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept;

  assign accept = rx_valid && rx_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    idle_d  = accept ? '0 : idle_q;
    op_d    = op_q;
    arg_a_d = arg_a_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && rx_data == SYNC_BYTE) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (accept) begin
          cnt_d   = rx_data;
          sum_d   = rx_data;
          addr_d  = '0;
          state_d = (rx_data == 8'd0) ? S_CHECK : S_B0;
        end
      end
      S_B0: begin
        if (accept) begin
          op_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = S_B1;
        end
      end
      S_B1: begin
        if (accept) begin
          arg_a_d = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = S_B2;
        end
      end
      S_B2: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {op_q, arg_a_q, rx_data};
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - 8'd1;
          sum_d   = sum_q + rx_data;
          state_d = (cnt_q == 8'd1) ? S_CHECK : S_B0;
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_d = S_RESULT;
          done_d  = (rx_data == sum_q);
          err_d   = (rx_data != sum_q);
        end
      end
      S_RESULT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Inactivity only counts while a frame is waiting for its next byte.
    if (!accept && state_q != S_IDLE && state_q != S_RESULT) begin
      if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
        state_d = S_RESULT;
        err_d   = 1'b1;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
    rx_ready_d = (state_d != S_RESULT);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      sum_q      <= '0;
      idle_q     <= '0;
      op_q       <= '0;
      arg_a_q    <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      sum_q      <= sum_d;
      idle_q     <= idle_d;
      op_q       <= op_d;
      arg_a_q    <= arg_a_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign rom_w_enable = we_q;
  assign rom_w_addr   = waddr_q;
  assign rom_w_data   = wdata_q;
  assign busy         = busy_q;
  assign cpu_hold     = busy_q;
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a byte-position frame model checked every cycle,
// plus directed frames with hand-computed ROM writes and result pulses.
module tb_program_loader;
  localparam int         AW      = 4;
  localparam int         TMO     = 16;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          rom_w_enable;
  logic [AW-1:0] rom_w_addr;
  logic [23:0]   rom_w_data;
  logic          cpu_hold;
  logic          busy;
  logic          load_done;
  logic          load_error;
  logic [2:0]    dbg_state;

  program_loader #(.ADDR_W(AW), .SYNC_BYTE(SYNC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rom_w_enable(rom_w_enable), .rom_w_addr(rom_w_addr),
    .rom_w_data(rom_w_data), .cpu_hold(cpu_hold), .busy(busy),
    .load_done(load_done), .load_error(load_error), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // k = bytes accepted in the open frame (0 = waiting for sync).
  int          k = 0, n = 0, sum = 0, idle = 0;
  bit          in_result = 1'b0;
  logic [23:0] word = '0;
  logic        m_ready = 1'b0, m_we = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [23:0] m_data = '0;

  always @(posedge clk) begin
    logic acc;
    logic [7:0] d;
    int p;
    acc = rx_valid && m_ready;
    d = rx_data;
    m_we = 1'b0; m_done = 1'b0; m_err = 1'b0;
    if (rst) begin
      k = 0; in_result = 1'b0; idle = 0;
      m_ready = 1'b0; m_busy = 1'b0; m_addr = '0; m_data = '0;
    end else if (in_result) begin
      in_result = 1'b0; k = 0; m_ready = 1'b1; m_busy = 1'b0;
    end else begin
      if (k == 0) begin
        if (acc && d == SYNC) begin k = 1; idle = 0; end
      end else if (acc) begin
        idle = 0;
        if (k == 1) begin
          n = d; sum = d; k = 2;
        end else if (k < 3 * n + 2) begin
          p = k - 2;
          sum = (sum + d) % 256;
          word = {word[15:0], d};
          if (p % 3 == 2) begin
            m_we = 1'b1;
            m_addr = AW'((p / 3) % (1 << AW));
            m_data = word;
          end
          k++;
        end else begin
          in_result = 1'b1;
          if (d == 8'(sum)) m_done = 1'b1; else m_err = 1'b1;
        end
      end else begin
        idle++;
        if (idle == TMO) begin in_result = 1'b1; m_err = 1'b1; end
      end
      m_busy  = in_result || (k != 0);
      m_ready = !in_result;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("outputs {ready,we,busy,hold,done,err}",
            {26'd0, rx_ready, rom_w_enable, busy, cpu_hold, load_done, load_error},
            {26'd0, m_ready, m_we, m_busy, m_busy, m_done, m_err});
      check("rom_w_addr", 32'(rom_w_addr), 32'(m_addr));
      check("rom_w_data", 32'(rom_w_data), 32'(m_data));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [27:0] exp_q[$];
  logic [27:0] act_q[$];
  int done_cnt = 0, err_cnt = 0, last_acc_cyc = 0, err_cyc = 0;

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (rom_w_enable) act_q.push_back({rom_w_addr, rom_w_data});
      if (load_done) done_cnt++;
      if (load_error) begin err_cnt++; err_cyc = cyc; end
      if (rx_valid && rx_ready) last_acc_cyc = cyc;
    end
  end

  task automatic clear_log();
    @(negedge clk);
    act_q.delete(); exp_q.delete();
    done_cnt = 0; err_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic check_writes(input string name, input int exp_done, input int exp_err);
    check({name, " write count"}, 32'(act_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && act_q.size() > 0)
      check({name, " write"}, 32'(act_q.pop_front()), 32'(exp_q.pop_front()));
    check({name, " done pulses"}, 32'(done_cnt), 32'(exp_done));
    check({name, " error pulses"}, 32'(err_cnt), 32'(exp_err));
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    logic ok = 1'b0;
    rx_valid = 1'b1; rx_data = b;
    while (!ok && t < 50) begin
      @(negedge clk); ok = rx_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!ok) check("byte accept timeout", 32'd0, 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int c);
    rx_valid = 1'b0;
    for (int i = 0; i < c; i++) begin
      rx_data = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] f[$];
    int nn, cs;
    logic [7:0] b;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset outputs",
          {23'd0, rx_ready, rom_w_enable, rom_w_addr, busy, cpu_hold, load_done, load_error},
          32'd0);
    check("reset rom_w_data", 32'(rom_w_data), 32'd0);
    @(posedge clk); #1;

    // Good frame
    clear_log();
    f = '{8'hA5, 8'h02, 8'h01, 8'h03, 8'h05, 8'h02, 8'h01, 8'hFF, 8'h0D};
    send_list(f); idle_cycles(4);
    exp_q.push_back({4'h0, 24'h010305}); exp_q.push_back({4'h1, 24'h0201FF});
    check_writes("good", 1, 0);

    // Bad checksum
    clear_log();
    f = '{8'hA5, 8'h02, 8'h01, 8'h03, 8'h05, 8'h02, 8'h01, 8'hFF, 8'h0E};
    send_list(f); idle_cycles(4);
    exp_q.push_back({4'h0, 24'h010305}); exp_q.push_back({4'h1, 24'h0201FF});
    check_writes("badsum", 0, 1);

    // Empty frames
    clear_log();
    f = '{8'hA5, 8'h00, 8'h00}; send_list(f); idle_cycles(4);
    check_writes("empty ok", 1, 0);
    clear_log();
    f = '{8'hA5, 8'h00, 8'h01}; send_list(f); idle_cycles(4);
    check_writes("empty bad", 0, 1);

    // Junk before the frame; 01+AA+BB+CC = 0x232 -> 0x32
    clear_log();
    f = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'h32};
    send_list(f); idle_cycles(4);
    exp_q.push_back({4'h0, 24'hAABBCC});
    check_writes("junk", 1, 0);

    // Timeout, then a normal frame
    clear_log();
    f = '{8'hA5, 8'h01, 8'h11}; send_list(f); idle_cycles(25);
    check("timeout latency", 32'(err_cyc - last_acc_cyc), 32'd17);
    check_writes("timeout", 0, 1);
    clear_log();
    f = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h07}; send_list(f); idle_cycles(4);
    exp_q.push_back({4'h0, 24'h010203});
    check_writes("after timeout", 1, 0);

    // Reset mid-frame
    clear_log();
    f = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04}; send_list(f);
    do_reset();
    @(negedge clk);
    check("mid-frame reset outputs",
          {23'd0, rx_ready, rom_w_enable, rom_w_addr, busy, cpu_hold, load_done, load_error},
          32'd0);
    @(posedge clk); #1;
    idle_cycles(20);
    exp_q.push_back({4'h0, 24'h010203});
    check_writes("reset", 0, 0);
    clear_log();
    f = '{8'hA5, 8'h01, 8'h07, 8'h08, 8'h09, 8'h19}; send_list(f); idle_cycles(4);
    exp_q.push_back({4'h0, 24'h070809});
    check_writes("after reset", 1, 0);

    // Address wrap with 18 words into a 16-entry ROM
    clear_log();
    f = '{8'hA5, 8'h12};
    cs = 18;
    for (int i = 0; i < 54; i++) begin f.push_back(8'(i * 7 + 1)); cs += i * 7 + 1; end
    f.push_back(8'(cs));
    send_list(f); idle_cycles(4);
    for (int w = 0; w < 18; w++)
      exp_q.push_back({4'(w % 16), 8'(w * 21 + 1), 8'(w * 21 + 8), 8'(w * 21 + 15)});
    check_writes("wrap", 1, 0);

    // Random frames with junk, gaps, bad checksums and occasional stalls
    for (int fr = 0; fr < 40; fr++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 8'hA4)));
      nn = $urandom_range(0, 20);
      cs = nn;
      send_byte(SYNC);
      send_byte(8'(nn));
      for (int i = 0; i < 3 * nn; i++) begin
        b = 8'($urandom);
        cs += b;
        if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        if ($urandom_range(0, 99) == 0) idle_cycles(TMO + 2);
        send_byte(b);
      end
      if ($urandom_range(0, 3) == 0) cs += $urandom_range(1, 255);
      send_byte(8'(cs));
      if ($urandom_range(0, 1) == 0) idle_cycles($urandom_range(0, 4));
    end
    idle_cycles(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global time limit reached: got running expected finished");
    $fatal(1, "time limit");
  end
endmodule
